// File: rtl/instr_queue_reg.sv
// rtl/instr_queue_reg.sv - prefetch queue feeding the IR with PC tag; FETCH_DECODE_FIELDS_EN adds decoded field outputs
module instr_queue_reg #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              push_valid,
    output logic              push_ready,
    input  logic [DATA_W-1:0] push_data,
    input  logic [ADDR_W-1:0] push_pc,
    input  logic              ir_load,
    output logic [DATA_W-1:0] instruction,
    output logic [ADDR_W-1:0] ir_pc,
    output logic              ir_valid,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full
`ifdef FETCH_DECODE_FIELDS_EN
    ,
    output logic [5:0]        opcode,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [4:0]        shamt,
    output logic [5:0]        funct,
    output logic [15:0]       imm16
`endif
);

    localparam int PTR_W = $clog2(DEPTH);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("instr_queue_reg: DEPTH must be a power of two and at least 2");
    end

    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [ADDR_W-1:0] mem_pc   [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    logic push_fire;
    logic bypass;
    logic do_write;
    logic do_pop;

    assign empty      = (count == '0);
    assign full       = (count == CNT_W'(DEPTH));
    assign push_ready = !full && !flush;
    assign push_fire  = push_valid && push_ready;

    // An empty queue hands the offered word straight to the IR instead of storing it.
    assign bypass   = ir_load && empty && push_fire;
    assign do_write = push_fire && !bypass;
    assign do_pop   = ir_load && !empty && !flush;

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem_data[wr_ptr] <= push_data;
            mem_pc[wr_ptr]   <= push_pc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            instruction <= '0;
            ir_pc       <= '0;
            ir_valid    <= 1'b0;
        end else if (flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            instruction <= '0;
            ir_valid    <= 1'b0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_write && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (!do_write && do_pop) begin
                count <= count - CNT_W'(1);
            end
            if (ir_load) begin
                if (!empty) begin
                    instruction <= mem_data[rd_ptr];
                    ir_pc       <= mem_pc[rd_ptr];
                    ir_valid    <= 1'b1;
                end else if (push_valid) begin
                    instruction <= push_data;
                    ir_pc       <= push_pc;
                    ir_valid    <= 1'b1;
                end else begin
                    ir_valid    <= 1'b0;
                end
            end
        end
    end

`ifdef FETCH_DECODE_FIELDS_EN
    if (DATA_W != 32) begin : g_bad_width
        $error("instr_queue_reg: decoded fields need DATA_W == 32");
    end

    assign opcode = instruction[31:26];
    assign rs     = instruction[25:21];
    assign rt     = instruction[20:16];
    assign rd     = instruction[15:11];
    assign shamt  = instruction[10:6];
    assign funct  = instruction[5:0];
    assign imm16  = instruction[15:0];
`endif

endmodule

// File: tb/tb_instr_queue_reg.sv
// tb/tb_instr_queue_reg.sv - scoreboard bench for instr_queue_reg
module tb_instr_queue_reg;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        push_valid = 1'b0;
    logic        push_ready;
    logic [31:0] push_data = '0;
    logic [31:0] push_pc = '0;
    logic        ir_load = 1'b0;
    logic [31:0] instruction;
    logic [31:0] ir_pc;
    logic        ir_valid;
    logic [2:0]  count;
    logic        empty;
    logic        full;
`ifdef FETCH_DECODE_FIELDS_EN
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm16;
`endif

    instr_queue_reg #(.DATA_W(32), .ADDR_W(32), .DEPTH(4)) dut (
        .clk(clk),
        .reset(reset),
        .flush(flush),
        .push_valid(push_valid),
        .push_ready(push_ready),
        .push_data(push_data),
        .push_pc(push_pc),
        .ir_load(ir_load),
        .instruction(instruction),
        .ir_pc(ir_pc),
        .ir_valid(ir_valid),
        .count(count),
        .empty(empty),
        .full(full)
`ifdef FETCH_DECODE_FIELDS_EN
        ,
        .opcode(opcode),
        .rs(rs),
        .rt(rt),
        .rd(rd),
        .shamt(shamt),
        .funct(funct),
        .imm16(imm16)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [31:0] pc;
        logic        v;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic last_push_ready;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock of stimulus; IR-changing cycles queue their expected IR state.
    task automatic tick(input logic pv, input logic [31:0] pd, input logic [31:0] pp,
                        input logic ld, input logic fl,
                        input logic [31:0] ed, input logic [31:0] ep, input logic ev);
        exp_t e;
        push_valid = pv;
        push_data  = pd;
        push_pc    = pp;
        ir_load    = ld;
        flush      = fl;
        if (ld || fl) begin
            e.d = ed;
            e.pc = ep;
            e.v = ev;
            sb.push_back(e);
        end
        #1;
        last_push_ready = push_ready;
        @(posedge clk);
        #1;
        push_valid = 1'b0;
        ir_load    = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic push(input logic [31:0] pd, input logic [31:0] pp);
        tick(1'b1, pd, pp, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic load(input logic [31:0] ed, input logic [31:0] ep, input logic ev);
        tick(1'b0, '0, '0, 1'b1, 1'b0, ed, ep, ev);
    endtask

    // Monitor: after any edge that sampled ir_load or flush, compare the IR against the scoreboard.
    initial begin
        logic ev;
        exp_t e;
        forever begin
            @(posedge clk);
            ev = (ir_load || flush) && !reset;
            #2;
            if (ev) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("instruction", 64'(instruction), 64'(e.d));
                    chk("ir_pc", 64'(ir_pc), 64'(e.pc));
                    chk("ir_valid", 64'(ir_valid), 64'(e.v));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("rst_instruction", 64'(instruction), 64'd0);
        chk("rst_ir_pc", 64'(ir_pc), 64'd0);
        chk("rst_ir_valid", 64'(ir_valid), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_push_ready", 64'(push_ready), 64'd1);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // In-order fetch of three words
        push(32'h8C010004, 32'h0);
        push(32'h20020005, 32'h4);
        push(32'h00221820, 32'h8);
        chk("fill3_count", 64'(count), 64'd3);
        load(32'h8C010004, 32'h0, 1'b1);
        load(32'h20020005, 32'h4, 1'b1);
        load(32'h00221820, 32'h8, 1'b1);
        chk("drain3_empty", 64'(empty), 64'd1);
        chk("drain3_count", 64'(count), 64'd0);
`ifdef FETCH_DECODE_FIELDS_EN
        chk("dec_rs", 64'(rs), 64'd1);
        chk("dec_rt", 64'(rt), 64'd2);
        chk("dec_rd", 64'(rd), 64'd3);
        chk("dec_funct", 64'(funct), 64'h20);
`endif

        // Full queue back-pressure
        push(32'hA0000000, 32'h100);
        push(32'hA0000001, 32'h104);
        push(32'hA0000002, 32'h108);
        push(32'hA0000003, 32'h10C);
        chk("full_flag", 64'(full), 64'd1);
        chk("full_push_ready", 64'(push_ready), 64'd0);
        push(32'hA0000005, 32'h114);
        chk("full_reject_count", 64'(count), 64'd4);
        tick(1'b1, 32'hA0000005, 32'h114, 1'b1, 1'b0, 32'hA0000000, 32'h100, 1'b1);
        chk("full_load_ready", 64'(last_push_ready), 64'd0);
        chk("full_load_count", 64'(count), 64'd3);
        push(32'hA0000005, 32'h114);
        chk("refill_count", 64'(count), 64'd4);
        load(32'hA0000001, 32'h104, 1'b1);
        load(32'hA0000002, 32'h108, 1'b1);
        load(32'hA0000003, 32'h10C, 1'b1);
        load(32'hA0000005, 32'h114, 1'b1);
        chk("full_drain_empty", 64'(empty), 64'd1);

        // Bypass into an empty queue, then a load with nothing available
        tick(1'b1, 32'h3C01ABCD, 32'h40, 1'b1, 1'b0, 32'h3C01ABCD, 32'h40, 1'b1);
        chk("bypass_count", 64'(count), 64'd0);
        load(32'h3C01ABCD, 32'h40, 1'b0);
        chk("starve_count", 64'(count), 64'd0);

        // Flush beats simultaneous push and load
        push(32'hB0000000, 32'h200);
        push(32'hB0000001, 32'h204);
        load(32'hB0000000, 32'h200, 1'b1);
        push(32'hB0000002, 32'h208);
        chk("preflush_count", 64'(count), 64'd2);
        tick(1'b1, 32'hB0000003, 32'h20C, 1'b1, 1'b1, 32'h0, 32'h200, 1'b0);
        chk("flush_push_ready", 64'(last_push_ready), 64'd0);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_empty", 64'(empty), 64'd1);
        load(32'h0, 32'h200, 1'b0);

        // Pointer wrap: seven words through a four-entry queue
        push(32'hC0000000, 32'h300);
        push(32'hC0000001, 32'h304);
        for (int i = 2; i < 7; i++) begin
            tick(1'b1, 32'hC0000000 + 32'(i), 32'h300 + 32'(4 * i), 1'b1, 1'b0,
                 32'hC0000000 + 32'(i - 2), 32'h300 + 32'(4 * (i - 2)), 1'b1);
            chk("wrap_count", 64'(count), 64'd2);
        end
        load(32'hC0000005, 32'h314, 1'b1);
        load(32'hC0000006, 32'h318, 1'b1);
        chk("wrap_empty", 64'(empty), 64'd1);

        // Asynchronous reset mid-cycle
        push(32'hD0000000, 32'h400);
        push(32'hD0000001, 32'h404);
        push(32'hD0000002, 32'h408);
        push(32'hD0000003, 32'h40C);
        load(32'hD0000000, 32'h400, 1'b1);
        chk("prereset_count", 64'(count), 64'd3);
        #2;
        reset = 1'b1;
        #1;
        chk("areset_count", 64'(count), 64'd0);
        chk("areset_ir_valid", 64'(ir_valid), 64'd0);
        chk("areset_instruction", 64'(instruction), 64'd0);
        chk("areset_ir_pc", 64'(ir_pc), 64'd0);
        chk("areset_empty", 64'(empty), 64'd1);
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;
        load(32'h0, 32'h0, 1'b0);
        chk("postreset_count", 64'(count), 64'd0);

        @(posedge clk);
        #3;
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_queue_reg.md
Name: instr_queue_reg

Overview:
Parametrised successor to the single instruction register in the multi-cycle datapath. It combines a DEPTH-entry instruction prefetch queue with the architectural IR and the PC tag of the instruction the IR holds. Memory-fetch logic pushes fetched words; the control FSM pulls the next word into the IR with ir_load, which replaces IRWrite. Flush support covers branch/jump redirects.

Parameters:
DATA_W, 32, instruction word width
ADDR_W, 32, PC tag width
DEPTH, 4, queue entries; power of two, at least 2
CNT_W, $clog2(DEPTH+1), width of the occupancy count

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
flush  input  1  discard the queue and invalidate the IR (redirect)
push_valid  input  1  fetch side offers a word
push_ready  output  1  queue can accept; combinational, = !full && !flush
push_data  input  DATA_W  fetched instruction word
push_pc  input  ADDR_W  PC of push_data
ir_load  input  1  control FSM requests the next instruction into the IR
instruction  output  DATA_W  current IR contents (registered)
ir_pc  output  ADDR_W  PC tag of instruction (registered)
ir_valid  output  1  instruction holds a live, unflushed word
count  output  CNT_W  queue occupancy, 0..DEPTH
empty  output  1  count == 0
full  output  1  count == DEPTH
opcode/rs/rt/rd/shamt/funct/imm16  output  6/5/5/5/5/6/16  decoded fields (DECODE_FIELDS_EN only)

Behaviour:
- Reset (async, active-high): instruction=0, ir_pc=0, ir_valid=0, count=0, read and write pointers=0. After reset: empty=1, full=0, push_ready=1 unless flush is high.
- Storage: circular buffer with wrapping pointers of width log2(DEPTH). Count is tracked separately so full and empty are unambiguous.
- Push accepted = push_valid && push_ready. The word and its PC are written at the write pointer, and the write pointer increments modulo DEPTH.
- ir_load with queue non-empty: IR and ir_pc take the head entry on the next edge, ir_valid=1, read pointer increments. Latency from ir_load to instruction update is 1 cycle.
- ir_load with queue empty and push_valid=1: bypass. IR takes push_data/push_pc directly, ir_valid=1, and the queue is not written (count stays 0). push_ready is still 1.
- ir_load with queue empty and no push: instruction and ir_pc hold, ir_valid goes to 0.
- No ir_load: IR, ir_pc and ir_valid hold.
- Simultaneous accepted push and ir_load with count in 1..DEPTH-1: both happen and count is unchanged.
- When full, push_ready=0 even if ir_load is high in the same cycle; there is no same-cycle pass-through when full.
- flush has priority over push and ir_load. Next edge: count=0, pointers=0, ir_valid=0, instruction=0 (NOP), ir_pc holds. Pushes during flush are dropped because push_ready=0.
- Queue storage contents are not reset; only pointers and count are.
- Reset asserted mid-operation: all state returns to the reset values immediately, without waiting for a clock edge.

Optional Feature:
- Macro FETCH_DECODE_FIELDS_EN.
- Defined: field outputs are combinational slices of the registered instruction: opcode=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], shamt=[10:6], funct=[5:0], imm16=[15:0]. They are therefore 0 after reset or flush. Requires DATA_W=32; elaboration error otherwise.
- Not defined: these ports do not exist. Downstream logic slices instruction itself.

Test Plan:
- Reset, then push 0x8C010004 @pc 0x0, 0x20020005 @0x4, 0x00221820 @0x8 -> count=3; three ir_load pulses give instruction 0x8C010004, 0x20020005, 0x00221820 in order, each with the matching ir_pc, then empty=1.
- Push 4 words with DEPTH=4 -> full=1, push_ready=0; a 5th push_valid is not accepted; ir_load with push_valid held -> count=3 after the edge, and the 5th word is accepted on the following cycle.
- Empty queue, ir_load=1 with push_valid=1, data 0x3C01ABCD @0x40 -> next cycle instruction=0x3C01ABCD, ir_pc=0x40, ir_valid=1, count=0.
- count=2 with IR valid, assert flush together with push_valid and ir_load -> next cycle count=0, ir_valid=0, instruction=0, and the pushed word is lost.
- Push DEPTH+3 words interleaved with pops (pointer wrap) -> instructions emerge in FIFO order with correct PCs, and count never exceeds 4.
- Assert reset asynchronously mid-cycle with count=3 -> outputs go to their reset values before the next edge. With FETCH_DECODE_FIELDS_EN, loading 0x00221820 gives rs=1, rt=2, rd=3, funct=0x20.
